nested_down_counter: RTL
========================

Name: nested_down_counter

Overview:
- Loadable two-level (row, col) down-counter with a start/busy/done control handshake and a valid/ready output stream.
- Emits index pairs from (row_init, col_init) down to (0, 0). col is the inner loop.
- Reverse-order counterpart to the free-running up-counters. Used by the CNN datapath to walk kernel/window indices backwards, for example in flipped-kernel reads and buffer drains.
- Consumer is the address generator, which may stall through out_ready.

Parameters:
ROW_W, 4, width of the row index and row_init
COL_W, 4, width of the col index and col_init

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
row_init  input  ROW_W  starting row index, sampled on an accepted start
col_init  input  COL_W  starting col index, sampled on an accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse after the final beat is accepted
out_valid  output  1  current (row, col) is valid
out_ready  input  1  consumer accepts the current beat
row  output  ROW_W  current row index
col  output  COL_W  current col index
last  output  1  current beat is the final one, i.e. (0, 0)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy, done, out_valid and last =0; row and col =0; latched col_init register =0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch col_init into col_reload; row<=row_init; col<=col_init; go to RUN next edge.
  - out_valid rises in the cycle after start (latency 1).
- RUN:
  - out_valid=1. Beat accepted when out_valid & out_ready.
  - Accepted, col!=0 → col<=col-1.
  - Accepted, col==0, row!=0 → row<=row-1; col<=col_reload.
  - Accepted, col==0, row==0 → go to DONE; out_valid<=0.
  - out_ready=0 → row, col and last hold stable. No beat is dropped or repeated.
- last = (state==RUN) & (row==0) & (col==0). It is combinational from registers, with no extra latency.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. busy falls the same edge that done falls.
- Total beats per sweep = (row_init+1)*(col_init+1). row_init=0 with col_init=0 gives exactly 1 beat, with last=1 on that beat.
- Underflow never occurs. Decrements happen only when the index is nonzero.
- start in RUN or DONE is ignored; the inputs are not re-sampled.
- start in the same cycle that DONE→IDLE is ignored. The new sweep needs start while state==IDLE.
- Reset mid-sweep aborts immediately to the reset values. No done pulse is produced.
- All state and outputs are registered except last. No combinational path from out_ready to out_valid.

Optional Feature:
- Macro: NESTED_DOWN_COUNTER_STRIDE_EN.
- Defined:
  - Adds input col_stride [COL_W], latched at an accepted start.
  - An accepted beat with col >= stride sets col<=col-stride.
  - If col < stride, the beat is treated as end of row: reload or finish as in the col==0 rules.
  - last = (row==0) & (col < stride).
  - col_stride=0 is treated as 1.
- Undefined: no col_stride port; stride is fixed at 1; behaviour is exactly as above.

Test Plan:
- Reset then idle: rst low, release, 5 cycles with start=0 → busy=0, out_valid=0, done=0, row=col=0.
- Basic sweep: row_init=1, col_init=2, out_ready=1 → 6 beats (1,2)(1,1)(1,0)(0,2)(0,1)(0,0); last only on the 6th; done pulses one cycle later; busy then low.
- Backpressure: row_init=0, col_init=3; out_ready toggles 1,0,0,1,... → sequence 3,2,1,0 with no repeats or drops; col stable while out_ready=0.
- Degenerate sweep: row_init=0, col_init=0 → one beat (0,0) with last=1, then done; start pulsed during RUN is ignored.
- Mid-sweep reset: row_init=2, col_init=2, assert rst after 4 beats → outputs zero asynchronously, no done; a new start afterwards runs a full 9-beat sweep.
- Stride feature (macro defined): row_init=1, col_init=5, col_stride=2 → (1,5)(1,3)(1,1)(0,5)(0,3)(0,1); last on (0,1).

Source files
------------

// File: rtl/nested_down_counter.sv
`default_nettype none
// ============================================================================
// Module   : nested_down_counter
// Purpose  : Loadable two-level (row, col) down-counter with a start/busy/done
//            handshake and a valid/ready output stream. It walks index pairs
//            from (row_init, col_init) down to (0, 0), with col as the inner
//            loop. The consumer may stall the walk through out_ready.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-low reset
//            start      - one-cycle sweep request, honoured only in IDLE
//            row_init   - starting row, sampled on an accepted start
//            col_init   - starting col, sampled on an accepted start
//            col_stride - (NESTED_DOWN_COUNTER_STRIDE_EN only) col step,
//                         sampled on an accepted start, 0 treated as 1
//            busy       - high in RUN and DONE
//            done       - one-cycle pulse after the final beat is accepted
//            out_valid  - current (row, col) is valid
//            out_ready  - consumer accepts the current beat
//            row, col   - current index pair
//            last       - current beat is the final one of the sweep
// Options  : define NESTED_DOWN_COUNTER_STRIDE_EN to add the col_stride input.
// Revision : 1.0 - initial release
// ============================================================================
module nested_down_counter #(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] row_init,
    input  logic [COL_W-1:0] col_init,
`ifdef NESTED_DOWN_COUNTER_STRIDE_EN
    input  logic [COL_W-1:0] col_stride,
`endif
    output logic             busy,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [COL_W-1:0] r_col_reload;
    logic [COL_W-1:0] w_stride;
    logic             w_col_step;
    logic             w_accept;

`ifdef NESTED_DOWN_COUNTER_STRIDE_EN
    logic [COL_W-1:0] r_stride;

    // A zero stride would stall the inner loop forever; it is stored as 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stride <= COL_W'(1);
        end else if (r_state == ST_IDLE && start) begin
            r_stride <= (col_stride == '0) ? COL_W'(1) : col_stride;
        end
    end

    assign w_stride = r_stride;
`else
    assign w_stride = COL_W'(1);
`endif

    // The inner index can take another step only while it covers a full
    // stride; otherwise this beat ends the row. With unit stride this is
    // simply col != 0, so the index never underflows.
    assign w_col_step = (col >= w_stride);
    assign w_accept   = out_valid & out_ready;

    // last is the only combinational output: it follows the registered
    // indices directly so it lines up with the beat it describes.
    assign last = (r_state == ST_RUN) && (row == '0) && !w_col_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            out_valid    <= 1'b0;
            row          <= '0;
            col          <= '0;
            r_col_reload <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_col_reload <= col_init;
                        row          <= row_init;
                        col          <= col_init;
                        out_valid    <= 1'b1;
                        busy         <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (w_accept) begin
                        if (w_col_step) begin
                            col <= col - w_stride;
                        end else if (row != '0) begin
                            row <= row - 1'b1;
                            col <= r_col_reload;
                        end else begin
                            // Final beat taken: done is registered so it
                            // pulses during the single DONE cycle.
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
